// File: rtl/risc8_intc_if.sv
// risc8_intc_if: interrupt lines, COM bus and core handshake bundle for the interrupt controller
interface risc8_intc_if #(parameter int NSRC = 8);
  logic [NSRC-1:0] irq_in;
  logic [7:0]      com_addr;
  logic [7:0]      com_wr;
  logic            com_we;
  logic [7:0]      com_rd;
  logic            int_req;
  logic            int_ack;
  logic            int_ret;
  logic [2:0]      int_id;
  logic [15:0]     int_vec;
  modport master (
    output irq_in, com_addr, com_wr, com_we, int_ack, int_ret,
    input  com_rd, int_req, int_id, int_vec
  );
  modport slave (
    input  irq_in, com_addr, com_wr, com_we, int_ack, int_ret,
    output com_rd, int_req, int_id, int_vec
  );
endinterface

// File: rtl/risc8_intc.sv
// risc8_intc: edge-latched, fixed-priority interrupt controller with COM-bus registers
module risc8_intc #(
  parameter int          NSRC      = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter logic [15:0] VEC_BASE  = 16'h0004
) (
  input logic          clk,
  input logic          rst,
  risc8_intc_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_SVC  = 2'b10;
  logic [1:0]      r_state;
  logic            r_gie;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_prev;
  logic [2:0]      r_id;
  logic [8:0]      w_diff;
  logic            w_hit;
  logic            w_elig;
  logic            w_ack;
  logic            w_ret;
  logic [2:0]      w_cand;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_cm;
  logic [NSRC-1:0] w_ack_clr;
  logic [NSRC-1:0] w_w1c;
  // 9-bit offset so addresses below the window wrap to a large value and miss
  assign w_diff    = {1'b0, bus.com_addr} - {1'b0, BASE_ADDR};
  assign w_hit     = w_diff < 9'd4;
  assign w_edge    = bus.irq_in & ~r_prev;
  assign w_cm      = r_pend & r_mask;
  assign w_elig    = r_gie & |w_cm;
  assign w_ack     = r_state == S_REQ && bus.int_ack;
  assign w_ret     = r_state == S_SVC && bus.int_ret;
  assign w_ack_clr = w_ack ? NSRC'(1) << r_id : '0;
  assign w_w1c     = (bus.com_we && w_hit && w_diff[1:0] == 2'd2) ? bus.com_wr[NSRC-1:0] : '0;
  // lowest-index pending and unmasked source wins
  always_comb begin
    w_cand = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (w_cm[i]) w_cand = 3'(i);
  end
  assign bus.com_rd  = !w_hit                ? 8'h00 :
                       w_diff[1:0] == 2'd0   ? {7'b0, r_gie} :
                       w_diff[1:0] == 2'd1   ? 8'(r_mask) :
                       w_diff[1:0] == 2'd2   ? 8'(r_pend) :
                                               {r_state, 3'b0, r_id};
  assign bus.int_req = r_state == S_REQ;
  assign bus.int_id  = r_id;
  assign bus.int_vec = VEC_BASE + {11'b0, r_id, 2'b00};
  // control registers written from the COM bus
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gie  <= 1'b0;
      r_mask <= '0;
    end else begin
      if (bus.com_we && w_hit && w_diff[1:0] == 2'd0) r_gie <= bus.com_wr[0];
      if (bus.com_we && w_hit && w_diff[1:0] == 2'd1) r_mask <= bus.com_wr[NSRC-1:0];
    end
  end
  // edge capture; a fresh edge overrides any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= bus.irq_in;
      r_pend <= w_edge | (r_pend & ~w_ack_clr & ~w_w1c);
    end
  end
  // request sequencer; the id is frozen from IDLE->REQ until the next request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= (r_state == S_IDLE && w_elig) ? S_REQ :
                 w_ack ? S_SVC :
                 w_ret ? S_IDLE : r_state;
      if (r_state == S_IDLE && w_elig) r_id <= w_cand;
    end
  end
endmodule

// File: tb/tb_risc8_intc.sv
// tb_risc8_intc: table-driven directed check of the interrupt controller
module tb_risc8_intc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  risc8_intc_if #(.NSRC(8)) intf ();
  risc8_intc #(.NSRC(8), .BASE_ADDR(8'hF0), .VEC_BASE(16'h0004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );
  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        ret;
    logic [7:0]  raddr;
    logic        req;
    logic [2:0]  id;
    logic [15:0] vec;
    logic [7:0]  rd;
  } vec_t;
  vec_t vt[$];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input logic req, input logic [2:0] id,
                         input logic [15:0] vec, input logic [7:0] rd);
    chk({tag, ".req"}, 16'(intf.int_req), 16'(req));
    chk({tag, ".id"},  16'(intf.int_id),  16'(id));
    chk({tag, ".vec"}, intf.int_vec,      vec);
    chk({tag, ".rd"},  16'(intf.com_rd),  16'(rd));
  endtask
  task automatic step_read(input logic [7:0] a);
    @(posedge clk);
    #1;
    rst = 1'b0; intf.com_we = 1'b0; intf.int_ack = 1'b0; intf.int_ret = 1'b0;
    intf.com_addr = a;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
  initial begin
    intf.irq_in = '0; intf.com_addr = '0; intf.com_wr = '0; intf.com_we = 1'b0;
    intf.int_ack = 1'b0; intf.int_ret = 1'b0;
    //          rst   irq    we    addr   wdata  ack   ret   raddr  req   id    vec        rd
    vt.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b0, 3'd0, 16'h0004, 8'h00});
    vt.push_back('{1'b0, 8'h00, 1'b1, 8'hF1, 8'h04, 1'b0, 1'b0, 8'hF1, 1'b0, 3'd0, 16'h0004, 8'h04});
    vt.push_back('{1'b0, 8'h00, 1'b1, 8'hF0, 8'h01, 1'b0, 1'b0, 8'hF0, 1'b0, 3'd0, 16'h0004, 8'h01});
    vt.push_back('{1'b0, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd0, 16'h0004, 8'h04});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b1, 3'd2, 16'h000C, 8'h04});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF3, 1'b0, 3'd2, 16'h000C, 8'h82});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd2, 16'h000C, 8'h00});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b0, 3'd2, 16'h000C, 8'h02});
    vt.push_back('{1'b0, 8'h00, 1'b1, 8'hF1, 8'hFF, 1'b0, 1'b0, 8'hF1, 1'b0, 3'd2, 16'h000C, 8'hFF});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd2, 16'h000C, 8'h28});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b1, 3'd3, 16'h0010, 8'h43});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF2, 1'b0, 3'd3, 16'h0010, 8'h20});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b0, 3'd3, 16'h0010, 8'h03});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b1, 3'd5, 16'h0018, 8'h45});
    vt.push_back('{1'b0, 8'h28, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF2, 1'b0, 3'd5, 16'h0018, 8'h00});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b0, 3'd5, 16'h0018, 8'h05});
    vt.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd5, 16'h0018, 8'h08});
    vt.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b1, 3'd3, 16'h0010, 8'h43});
    vt.push_back('{1'b0, 8'h09, 1'b1, 8'hF1, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b1, 3'd3, 16'h0010, 8'h09});
    vt.push_back('{1'b0, 8'h09, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF2, 1'b0, 3'd3, 16'h0010, 8'h01});
    vt.push_back('{1'b0, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd3, 16'h0010, 8'h03});
    vt.push_back('{1'b0, 8'h0B, 1'b1, 8'hF1, 8'hFF, 1'b0, 1'b0, 8'hF3, 1'b0, 3'd3, 16'h0010, 8'h83});
    vt.push_back('{1'b0, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b0, 3'd3, 16'h0010, 8'h03});
    vt.push_back('{1'b0, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b1, 3'd0, 16'h0004, 8'h40});
    vt.push_back('{1'b0, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF2, 1'b0, 3'd0, 16'h0004, 8'h02});
    vt.push_back('{1'b0, 8'h00, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b1, 8'hF3, 1'b0, 3'd0, 16'h0004, 8'h00});
    vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd0, 16'h0004, 8'h00});
    vt.push_back('{1'b0, 8'h10, 1'b1, 8'hF2, 8'h10, 1'b0, 1'b0, 8'hF2, 1'b0, 3'd0, 16'h0004, 8'h10});
    vt.push_back('{1'b0, 8'h10, 1'b1, 8'hF2, 8'h10, 1'b0, 1'b0, 8'hF2, 1'b1, 3'd4, 16'h0014, 8'h00});
    vt.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF3, 1'b1, 3'd4, 16'h0014, 8'h44});
    vt.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF3, 1'b0, 3'd4, 16'h0014, 8'h84});
    vt.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 3'd4, 16'h0014, 8'h00});
    vt.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hEF, 1'b0, 3'd4, 16'h0014, 8'h00});
    vt.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF4, 1'b0, 3'd4, 16'h0014, 8'h00});
    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      rst = vt[k].rst; intf.irq_in = vt[k].irq; intf.com_we = vt[k].we;
      intf.com_addr = vt[k].addr; intf.com_wr = vt[k].wdata;
      intf.int_ack = vt[k].ack; intf.int_ret = vt[k].ret;
      step_read(vt[k].raddr);
      chk_all($sformatf("v%0d", k), vt[k].req, vt[k].id, vt[k].vec, vt[k].rd);
    end
    // reset while in service, with line 0 held high through reset
    @(negedge clk);
    rst = 1'b1; intf.irq_in = 8'h01;
    step_read(8'hF3);
    chk_all("rst.status", 1'b0, 3'd0, 16'h0004, 8'h00);
    intf.com_addr = 8'hF1; #1;
    chk("rst.mask", 16'(intf.com_rd), 16'h0000);
    intf.com_addr = 8'hF0; #1;
    chk("rst.gie", 16'(intf.com_rd), 16'h0000);
    intf.com_addr = 8'h20; #1;
    chk("rst.outside", 16'(intf.com_rd), 16'h0000);
    intf.com_addr = 8'hF2; #1;
    chk("rst.pend0", 16'(intf.com_rd), 16'h0000);
    step_read(8'hF2);
    chk("held.edge", 16'(intf.com_rd), 16'h0001);
    chk("held.noreq", 16'(intf.int_req), 16'h0000);
    // enable source 0 and GIE, then wait a bounded time for the request
    @(negedge clk);
    intf.com_we = 1'b1; intf.com_addr = 8'hF1; intf.com_wr = 8'h01;
    step_read(8'hF3);
    @(negedge clk);
    intf.com_we = 1'b1; intf.com_addr = 8'hF0; intf.com_wr = 8'h01;
    step_read(8'hF3);
    chk("gie.noreq_yet", 16'(intf.int_req), 16'h0000);
    begin
      int cyc = 0;
      while (!intf.int_req && cyc < 8) begin
        step_read(8'hF3);
        cyc++;
      end
      chk("gie.latency", 16'(cyc), 16'd1);
      chk("gie.status", 16'(intf.com_rd), 16'h0040);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
